doubled_id_gen: RTL and testbench
=================================

// Module: doubled_id_gen
// PURPOSE
//  Producer counterpart of the repeated-half ID checker: enumerates, in ascending order, every
//  packed-BCD ID whose upper half equals its lower half (11, 22, ..., 1010, 1111, ...).
//  Only IDs inside a requested inclusive range are emitted.
//  Output is a valid/ready stream feeding the Day-2 scoring path or the checker in a self-test loop.
//  Replaces the exhaustive scan-and-check of every ID in a range.
// PARAMETERS
//  ID_DIGITS   11   BCD digits per ID; ID width = 4*ID_DIGITS.
//  HALF_MAX    5    max half length in digits (= ID_DIGITS/2, integer division).
// PORTS
//  clk         in   1     single clock; all logic rising-edge.
//  rst_n       in   1     asynchronous, active-low reset.
//  start       in   1     pulse in IDLE: latch range and begin enumeration.
//  range_lo    in   44    inclusive lower bound, packed BCD, digit 0 at [3:0].
//  range_hi    in   44    inclusive upper bound, packed BCD.
//  id_out      out  44    emitted doubled ID, packed BCD, zero-extended.
//  id_valid    out  1     id_out holds a valid ID.
//  id_ready    in   1     consumer accepts id_out on the cycle where id_valid & id_ready.
//  busy        out  1     high in SCAN and EMIT.
//  done        out  1     one-cycle pulse when enumeration ends.
// BEHAVIOUR
//  - Reset: state=IDLE; id_out=0, id_valid=0, busy=0, done=0; half=1, k=1; latched bounds=0.
//  - Internal state:
//      half = BCD counter of k digits; k = half length (1..HALF_MAX+1).
//      cand = {half in digits [2k-1:k], half in digits [k-1:0]}, upper digits 0 (combinational).
//  - Comparisons: cand vs bounds are unsigned compares on the 44-bit packed vectors.
//    This is valid because BCD ordering equals binary ordering.
//  - FSM:
//    IDLE: start=1 -> latch range_lo/hi, half=1, k=1, go SCAN next cycle.
//          start is ignored in every other state.
//    SCAN: one candidate per cycle.
//      - k>HALF_MAX or cand>hi  -> DONE.
//      - else cand>=lo          -> id_out<=cand, id_valid<=1, go EMIT.
//      - else                   -> advance half, stay SCAN.
//    EMIT: id_out and id_valid held stable while id_ready=0.
//      - On handshake: id_valid<=0, advance half, go SCAN.
//      - Next valid ID appears no earlier than 2 cycles after the handshake.
//    DONE: done=1 for exactly one cycle, then IDLE.
//  - Advance half: BCD increment.
//      - If half was all 9s in k digits: k<=k+1, half<=10^k (a 1 followed by k zeros).
//      - Example: k=2, half=99 -> k=3, half=100.
//  - Latency: start at cycle N -> first SCAN at N+1.
//    If the first candidate is in range, id_valid rises at N+2.
//  - Boundary conditions:
//      - lo>hi: nothing emitted, done pulses.
//      - lo=hi=valid doubled ID: exactly one emit.
//      - hi with an odd digit count: enumeration stops at the k=HALF_MAX exhaustion.
//      - lo=0: treated as lo=1.
//      - Non-BCD digits on the bound inputs: result undefined.
//  - rst_n asserted mid-operation (any state, including EMIT with id_valid=1):
//      - Immediate return to the reset values.
//      - No done pulse is generated.
// CONFIGURATION
//  - SUM_EN defined:
//      - Adds output sum_out (64 bits, 16-digit packed BCD).
//      - Cleared to 0 on start and on reset.
//      - On every id handshake, sum_out <= sum_out + id_out using a digitwise BCD adder.
//      - sum_out is stable and final in the done cycle.
//      - Overflow beyond 16 digits wraps modulo 10^16.
//  - SUM_EN undefined: no sum_out port and no adder logic; all other behaviour identical.
// TESTING
//  T1 lo=0x10, hi=0x22, id_ready=1 -> emits 0x11, 0x22; then done; 2 valids total.
//  T2 lo=0x95, hi=0x115 -> emits 0x99 only; 0x1010 > hi -> done.
//  T3 lo=0x998, hi=0x1012 -> emits 0x1010 only (k rollover 99 -> 100 exercised).
//  T4 lo=0x11, hi=0x33, id_ready low 5 cycles on first valid:
//      -> id_out=0x11 held stable 5 cycles; then 0x22, 0x33 follow.
//  T5 lo=0x50, hi=0x40 -> zero valids, single done pulse, busy drops.
//  T6 rst_n pulled low while id_valid=1 -> id_valid=0, busy=0 same cycle; no done.
//     [SUM_EN] lo=1, hi=0x99 -> 9 emits, sum_out=0x495 at done.

Source files
------------

// File: rtl/doubled_id_gen.sv
// doubled_id_gen: streams, in ascending order, every packed-BCD ID whose upper half repeats its
// lower half and lies inside [range_lo, range_hi]. Optional macro SUM_EN adds a BCD running sum.
module doubled_id_gen #(
  parameter int ID_DIGITS = 11,
  parameter int HALF_MAX  = ID_DIGITS / 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*ID_DIGITS-1:0] range_lo,
  input  logic [4*ID_DIGITS-1:0] range_hi,
  output logic [4*ID_DIGITS-1:0] id_out,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic                   busy,
  output logic                   done
`ifdef SUM_EN
  ,
  output logic [63:0]            sum_out
`endif
);

  localparam int IDW = 4 * ID_DIGITS;
  localparam int HND = HALF_MAX + 1;
  localparam int HW  = 4 * HND;
  localparam int KW  = $clog2(HND + 1);
  localparam logic [KW-1:0] K_MAX = KW'(HALF_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t         r_state;
  logic [HW-1:0]  r_half;
  logic [KW-1:0]  r_k;
  logic [IDW-1:0] r_lo;
  logic [IDW-1:0] r_hi;

  logic [HW-1:0]  w_half_inc;
  logic           w_roll;
  logic [KW+1:0]  w_shift;
  logic [IDW-1:0] w_cand;
  logic           w_end;
  logic           w_hs;

  function automatic logic [HW-1:0] bcd_inc(input logic [HW-1:0] v);
    logic [HW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < HND; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          c = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Incrementing past all-9s in k digits lands a carry in digit k, which signals a length change.
  assign w_shift    = {r_k, 2'b00};
  assign w_half_inc = bcd_inc(r_half);
  assign w_roll     = |(w_half_inc >> w_shift);
  assign w_cand     = (IDW'(r_half) << w_shift) | IDW'(r_half);
  assign w_end      = (r_k > K_MAX) || (w_cand > r_hi);
  assign w_hs       = id_valid & id_ready;

  // Enumeration FSM with registered stream and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_half   <= HW'(1'b1);
      r_k      <= KW'(1'b1);
      r_lo     <= '0;
      r_hi     <= '0;
      id_out   <= '0;
      id_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_lo    <= (range_lo == '0) ? IDW'(1'b1) : range_lo;
            r_hi    <= range_hi;
            r_half  <= HW'(1'b1);
            r_k     <= KW'(1'b1);
            busy    <= 1'b1;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_end) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_cand >= r_lo) begin
            id_out   <= w_cand;
            id_valid <= 1'b1;
            r_state  <= ST_EMIT;
          end else begin
            r_half <= w_half_inc;
            if (w_roll) r_k <= r_k + KW'(1'b1);
          end
        end
        ST_EMIT: begin
          if (w_hs) begin
            id_valid <= 1'b0;
            r_half   <= w_half_inc;
            if (w_roll) r_k <= r_k + KW'(1'b1);
            r_state  <= ST_SCAN;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          id_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SUM_EN
  function automatic logic [63:0] bcd_add64(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic [4:0]  d;
    logic        c;
    r = 64'd0;
    c = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
      if (d > 5'd9) begin
        r[4*i +: 4] = 4'(d - 5'd10);
        c = 1'b1;
      end else begin
        r[4*i +: 4] = d[3:0];
        c = 1'b0;
      end
    end
    return r;
  endfunction

  // Running BCD sum of accepted IDs; the carry out of digit 15 is dropped (mod 10^16).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_out <= 64'd0;
    end else if ((r_state == ST_IDLE) && start) begin
      sum_out <= 64'd0;
    end else if (w_hs) begin
      sum_out <= bcd_add64(sum_out, 64'(id_out));
    end
  end
`endif

endmodule

// File: tb/tb_doubled_id_gen.sv
// Bench for doubled_id_gen: directed vector table, hand-written reset/exhaustion sequences and
// randomized ranges checked against an arithmetic enumeration of doubled IDs.
module tb_doubled_id_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [43:0] range_lo;
  logic [43:0] range_hi;
  logic [43:0] id_out;
  logic        id_valid;
  logic        id_ready;
  logic        busy;
  logic        done;
  logic [63:0] sum_out;

  logic        s_start;
  logic [19:0] s_lo;
  logic [19:0] s_hi;
  logic [19:0] s_id;
  logic        s_valid;
  logic        s_ready;
  logic        s_busy;
  logic        s_done;
  logic [63:0] s_sum;

  int n_checks = 0;
  int n_errors = 0;

  doubled_id_gen u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .range_lo(range_lo), .range_hi(range_hi),
    .id_out(id_out), .id_valid(id_valid), .id_ready(id_ready), .busy(busy), .done(done)
`ifdef SUM_EN
    , .sum_out(sum_out)
`endif
  );

  // Narrow instance so the half-length exhaustion stop can be reached in few cycles.
  doubled_id_gen #(.ID_DIGITS(5)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .range_lo(s_lo), .range_hi(s_hi),
    .id_out(s_id), .id_valid(s_valid), .id_ready(s_ready), .busy(s_busy), .done(s_done)
`ifdef SUM_EN
    , .sum_out(s_sum)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dec2bcd(input longint v);
    logic [63:0] r;
    longint      t;
    r = 64'd0;
    t = v;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic longint bcd2dec(input logic [63:0] b);
    longint r;
    r = 0;
    for (int i = 15; i >= 0; i--) r = r * 10 + longint'(b[4*i +: 4]);
    return r;
  endfunction

  // Reference: doubled ID of half h (d digits) is h*10^d + h; collect those in [max(lo,1), hi].
  logic [43:0] exp_q[$];
  logic [63:0] exp_sum;

  task automatic build_model(input logic [43:0] lo, input logic [43:0] hi);
    longint lo_d, hi_d, p, id, s;
    exp_q.delete();
    s    = 0;
    lo_d = bcd2dec(64'(lo));
    hi_d = bcd2dec(64'(hi));
    if (lo_d == 0) lo_d = 1;
    p = 10;
    for (longint h = 1; h < 100000; h++) begin
      if (h == p) p = p * 10;
      id = h * p + h;
      if (id > hi_d) break;
      if (id >= lo_d) begin
        exp_q.push_back(44'(dec2bcd(id)));
        s = (s + id) % 64'd10000000000000000;
      end
    end
    exp_sum = dec2bcd(s);
  endtask

  task automatic run_range(input string name, input logic [43:0] lo, input logic [43:0] hi,
                           input int stall_pct, input int stall_first,
                           output int n_emit, output logic [43:0] first_id,
                           output logic [43:0] last_id, output int first_cyc);
    int          cyc;
    int          stalls;
    bit          fin;
    bit          held;
    logic [43:0] held_id;
    build_model(lo, hi);
    n_emit = 0; first_id = '0; last_id = '0; first_cyc = -1;
    fin = 1'b0; held = 1'b0; held_id = '0; stalls = 0;
    @(negedge clk);
    start = 1'b1; range_lo = lo; range_hi = hi; id_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_start"}, 64'(busy), 64'd1);
    cyc = 0;
    while (!fin && cyc < 20000) begin
      if (held) chk({name, "_hold"}, 64'({id_valid, id_out}), 64'({1'b1, held_id}));
      if (done) begin
        fin = 1'b1;
        held = 1'b0;
        start = 1'b0;
        id_ready = 1'b0;
        chk({name, "_count"}, 64'(n_emit), 64'(exp_q.size()));
        chk({name, "_busy_done"}, 64'(busy), 64'd0);
`ifdef SUM_EN
        chk({name, "_sum"}, sum_out, exp_sum);
`endif
      end else begin
        // Start pulses and bound changes while busy must have no effect.
        start = 1'($urandom_range(1));
        range_lo = {12'($urandom), $urandom};
        range_hi = {12'($urandom), $urandom};
        if (id_valid) begin
          if (first_cyc < 0) first_cyc = cyc;
          if (stalls < stall_first) begin
            id_ready = 1'b0;
            stalls++;
          end else begin
            id_ready = ($urandom_range(99) >= stall_pct);
          end
          held = !id_ready;
          held_id = id_out;
          if (id_ready) begin
            if (n_emit < exp_q.size()) chk({name, "_id"}, 64'(id_out), 64'(exp_q[n_emit]));
            else chk({name, "_extra_id"}, 64'(id_out), 64'd0);
            if (n_emit == 0) first_id = id_out;
            last_id = id_out;
            n_emit++;
          end
        end else begin
          held = 1'b0;
          id_ready = 1'($urandom_range(1));
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!fin) begin
      chk({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({name, "_done_width"}, 64'({done, id_valid, busy}), 64'd0);
    end
  endtask

  typedef struct {
    logic [43:0] lo;
    logic [43:0] hi;
    int          stall_first;
    int          exp_n;
    logic [43:0] exp_first;
    logic [43:0] exp_last;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[8];
  int          n_e;
  int          lat;
  int          cyc;
  int          cnt;
  int          dones;
  logic [43:0] f_id;
  logic [43:0] l_id;
  logic [19:0] s_last;

  initial begin
    vecs[0] = '{44'h10,     44'h22,     0, 2, 44'h11,     44'h22,     1};
    vecs[1] = '{44'h95,     44'h115,    0, 1, 44'h99,     44'h99,    -1};
    vecs[2] = '{44'h998,    44'h1012,   0, 1, 44'h1010,   44'h1010,  -1};
    vecs[3] = '{44'h11,     44'h33,     5, 3, 44'h11,     44'h33,     1};
    vecs[4] = '{44'h50,     44'h40,     0, 0, 44'h0,      44'h0,     -1};
    vecs[5] = '{44'h123123, 44'h123123, 0, 1, 44'h123123, 44'h123123, -1};
    vecs[6] = '{44'h0,      44'h55,     0, 5, 44'h11,     44'h55,     1};
    vecs[7] = '{44'h9999,   44'h101010, 0, 2, 44'h9999,   44'h100100, -1};

    rst_n = 1'b0; start = 1'b0; range_lo = '0; range_hi = '0; id_ready = 1'b0;
    s_start = 1'b0; s_lo = '0; s_hi = '0; s_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({id_out, id_valid, busy, done}), 64'd0);
`ifdef SUM_EN
    chk("reset_sum", sum_out, 64'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_range($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi, 0, vecs[i].stall_first,
                n_e, f_id, l_id, lat);
      chk($sformatf("vec%0d_n", i), 64'(n_e), 64'(vecs[i].exp_n));
      chk($sformatf("vec%0d_first", i), 64'(f_id), 64'(vecs[i].exp_first));
      chk($sformatf("vec%0d_last", i), 64'(l_id), 64'(vecs[i].exp_last));
      if (vecs[i].exp_lat >= 0) chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
    end

`ifdef SUM_EN
    run_range("sum", 44'h1, 44'h99, 0, 0, n_e, f_id, l_id, lat);
    chk("sum_final", sum_out, 64'h495);
`endif

    for (int i = 0; i < 12; i++) begin
      int lo_d, hi_d;
      lo_d = int'($urandom_range(150000));
      hi_d = lo_d + int'($urandom_range(400000)) - 40000;
      if (hi_d < 0) hi_d = 0;
      run_range($sformatf("rand%0d", i), 44'(dec2bcd(longint'(lo_d))), 44'(dec2bcd(longint'(hi_d))),
                int'($urandom_range(60)), 0, n_e, f_id, l_id, lat);
    end

    // Reset while an ID is being offered: everything returns to reset values at once, no done.
    @(negedge clk);
    start = 1'b1; range_lo = 44'h11; range_hi = 44'h99; id_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!id_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_valid_seen", 64'(id_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", 64'({id_out, id_valid, busy, done}), 64'd0);
`ifdef SUM_EN
    chk("rst_sum", sum_out, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy || id_valid) dones++;
    end
    chk("rst_quiet", 64'(dones), 64'd0);
    run_range("post_rst", 44'h20, 44'h44, 0, 0, n_e, f_id, l_id, lat);
    chk("post_rst_n", 64'(n_e), 64'd3);

    // Five-digit instance: every half 1..99 fits, so the stop comes from half-length exhaustion.
    @(negedge clk);
    s_lo = 20'h0; s_hi = 20'h99999; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    cnt = 0; s_last = '0; cyc = 0; dones = 0;
    while (dones == 0 && cyc < 2000) begin
      if (s_done) dones = 1;
      else if (s_valid) begin
        cnt++;
        s_last = s_id;
      end
      @(negedge clk);
      cyc++;
    end
    chk("small_done", 64'(dones), 64'd1);
    chk("small_count", 64'(cnt), 64'd99);
    chk("small_last", 64'(s_last), 64'h9999);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
